// File: rtl/window_ones_detector.sv
// Sliding-window ones detector over a serial bit stream. It counts the ones in the
// last win_len accepted samples (mode 0) or measures the length of the current alternating run (mode 1).
module window_ones_detector #(
    parameter int MAX_WIN    = 8,
    parameter int DEF_WIN    = 3,
    parameter int DEF_THRESH = 2,
    localparam int CNT_W     = $clog2(MAX_WIN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             x_i,
    input  logic             cfg_load_i,
    input  logic [CNT_W-1:0] win_len_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             mode_i,
    output logic             y_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_WIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [MAX_WIN-1:0]   r_hist;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_alt_len;
    logic [CNT_W-1:0]     r_fill;
    logic [CNT_W-1:0]     r_win_len;
    logic [CNT_W-1:0]     r_thresh;
    logic                 r_mode;
    logic                 r_y;
    logic                 r_full;

    logic [CNT_W-1:0]     w_win_clamp;
    logic [CNT_W-1:0]     w_thresh_clamp;
    logic                 w_old_bit;
    logic [CNT_W-1:0]     w_fill_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [CNT_W-1:0]     w_alt_nxt;
    state_t               w_state_nxt;
    logic                 w_y_nxt;

    // Clamp a requested configuration into the legal window/threshold range.
    always_comb begin
        w_win_clamp    = win_len_i;
        w_thresh_clamp = thresh_i;
        if (win_len_i == C_ZERO) begin
            w_win_clamp = C_ONE;
        end else if (win_len_i > C_MAX) begin
            w_win_clamp = C_MAX;
        end else begin
            w_win_clamp = win_len_i;
        end
        if (thresh_i == C_ZERO) begin
            w_thresh_clamp = C_ONE;
        end else if (thresh_i > w_win_clamp) begin
            w_thresh_clamp = w_win_clamp;
        end else begin
            w_thresh_clamp = thresh_i;
        end
    end

    // Next-state values for one accepted sample. The bit leaving the window is only subtracted once the window is full.
    always_comb begin
        w_old_bit   = r_hist[r_win_len - C_ONE];
        w_fill_nxt  = r_fill;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                w_fill_nxt  = r_fill + C_ONE;
                w_count_nxt = r_count + CNT_W'(x_i);
                w_state_nxt = (w_fill_nxt >= r_win_len) ? ST_RUN : ST_FILL;
            end
            ST_RUN: begin
                w_fill_nxt  = r_fill;
                w_count_nxt = r_count + CNT_W'(x_i) - CNT_W'(w_old_bit);
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_fill_nxt  = C_ZERO;
                w_count_nxt = C_ZERO;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (r_state == ST_IDLE) begin
            w_alt_nxt = C_ONE;
        end else if (x_i != r_hist[0]) begin
            w_alt_nxt = (r_alt_len == C_MAX) ? C_MAX : r_alt_len + C_ONE;
        end else begin
            w_alt_nxt = C_ONE;
        end

        if (r_mode) begin
            w_y_nxt = (w_alt_nxt >= r_win_len);
        end else begin
            w_y_nxt = (w_count_nxt >= r_thresh);
        end
    end

    // State and output registers: reset beats config load, and config load beats a sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hist    <= {MAX_WIN{1'b0}};
            r_count   <= C_ZERO;
            r_alt_len <= C_ZERO;
            r_fill    <= C_ZERO;
            r_win_len <= CNT_W'(DEF_WIN);
            r_thresh  <= CNT_W'(DEF_THRESH);
            r_mode    <= 1'b0;
            r_y       <= 1'b0;
            r_full    <= 1'b0;
        end else if (cfg_load_i) begin
            r_state   <= ST_IDLE;
            r_hist    <= {MAX_WIN{1'b0}};
            r_count   <= C_ZERO;
            r_alt_len <= C_ZERO;
            r_fill    <= C_ZERO;
            r_win_len <= w_win_clamp;
            r_thresh  <= w_thresh_clamp;
            r_mode    <= mode_i;
            r_y       <= 1'b0;
            r_full    <= 1'b0;
        end else if (en_i) begin
            r_state   <= w_state_nxt;
            r_hist    <= {r_hist[MAX_WIN-2:0], x_i};
            r_count   <= w_count_nxt;
            r_alt_len <= w_alt_nxt;
            r_fill    <= w_fill_nxt;
            r_y       <= w_y_nxt;
            r_full    <= (w_state_nxt == ST_RUN);
        end else begin
            r_state   <= r_state;
            r_hist    <= r_hist;
            r_count   <= r_count;
            r_alt_len <= r_alt_len;
            r_fill    <= r_fill;
            r_y       <= r_y;
            r_full    <= r_full;
        end
    end

    assign y_o     = r_y;
    assign count_o = r_count;
    assign full_o  = r_full;

endmodule

// File: doc/window_ones_detector.md
WINDOW_ONES_DETECTOR -- requirements
Module: window_ones_detector

Interface
REQ-001 The module SHALL take parameter MAX_WIN, default 8, as the maximum window depth in samples (legal range 2..64).
REQ-002 The module SHALL take parameter DEF_WIN, default 3, as the reset value of the window length.
REQ-003 The module SHALL take parameter DEF_THRESH, default 2, as the reset value of the ones threshold.
REQ-004 The module SHALL use CNT_W = clog2(MAX_WIN+1) as its count width.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port en_i, input, 1 bit: sample valid; x_i is accepted on an edge where en_i=1.
REQ-008 The module SHALL have port x_i, input, 1 bit: serial sample.
REQ-009 The module SHALL have port cfg_load_i, input, 1 bit: loads win_len_i, thresh_i and mode_i, then restarts the window.
REQ-010 The module SHALL have port win_len_i, input, CNT_W bits: requested window length.
REQ-011 The module SHALL have port thresh_i, input, CNT_W bits: requested ones threshold.
REQ-012 The module SHALL have port mode_i, input, 1 bit: 0 = ones-count mode, 1 = alternation mode.
REQ-013 The module SHALL have port y_o, output, 1 bit: registered detect flag.
REQ-014 The module SHALL have port count_o, output, CNT_W bits: number of ones in the current window.
REQ-015 The module SHALL have port full_o, output, 1 bit: window has received win_len samples since the last clear.

Function
REQ-016 On cfg_load_i, the module SHALL clamp win_len_i to 1..MAX_WIN and thresh_i to 1..clamped window length before registering them (win_len_q, thresh_q, mode_q).
REQ-017 The module SHALL hold history in a shift register hist[MAX_WIN-1:0], newest sample in bit 0, shifting only on accepted samples.
REQ-018 The state machine SHALL have states IDLE, FILL and RUN: IDLE -> FILL on the first accepted sample; FILL -> RUN when the accepted sample brings fill count to win_len_q; RUN stays in RUN.
REQ-019 full_o SHALL be 1 exactly in RUN.
REQ-020 count_o SHALL equal popcount(hist[win_len_q-1:0]), updated incrementally: in FILL, count + x_i; in RUN, count + x_i - hist[win_len_q-1]; it never exceeds win_len_q.
REQ-021 In mode 0, y_o SHALL be (count after update >= thresh_q); early assertion in FILL is allowed because count is monotonic there.
REQ-022 In mode 1, alt_len SHALL become 1 on the first sample after a clear, then +1 if x_i != hist[0], else 1, saturating at MAX_WIN.
REQ-023 In mode 1, y_o SHALL be (alt_len >= win_len_q), which implies full_o=1.
REQ-024 Latency SHALL be one cycle: y_o, count_o and full_o reflect the window including the sample accepted on edge k, visible immediately after edge k.
REQ-025 When en_i=0, all state and outputs SHALL hold.
REQ-026 cfg_load_i SHALL clear hist, count, alt_len and fill count, set state to IDLE and zero y_o, count_o and full_o on the next edge.
REQ-027 cfg_load_i SHALL win over en_i in the same cycle; that sample is dropped.
REQ-028 The implementation SHALL have no combinational path from inputs to outputs.

Reset
REQ-029 On reset, the module SHALL set state=IDLE; hist=0; count, alt_len and fill count = 0; y_o=0, count_o=0, full_o=0.
REQ-030 On reset, the module SHALL set win_len_q=DEF_WIN, thresh_q=DEF_THRESH and mode_q=0.
REQ-031 Reset SHALL override cfg_load_i and en_i; reset asserted mid-stream SHALL discard history, with no stale output after release.

Verification
REQ-032 The bench SHALL drive defaults (win 3, thresh 2, mode 0) with en_i=1 and x_i = 0,1,0,1,1,0,0,1,1 -> y_o after each edge = 0,0,0,1,1,1,0,0,1; count_o = 0,1,1,2,2,2,1,1,2; full_o rises after the 3rd sample.
REQ-033 The bench SHALL cfg_load win=4, mode=1, then drive x_i = 1,0,1,0,0 -> y_o = 0,0,0,1,0; alt_len after the last sample = 1.
REQ-034 The bench SHALL run defaults with en_i toggled 1,0,1,0,1 while x_i=1 throughout -> count_o = 1,1,2,2,3; y_o rises only after the 2nd accepted sample.
REQ-035 The bench SHALL cfg_load win_len_i=0, thresh_i=15 with MAX_WIN=8 -> win_len_q=1, thresh_q=1; a single x_i=1 gives y_o=1, and a following x_i=0 gives y_o=0.
REQ-036 The bench SHALL assert cfg_load_i and en_i together with x_i=1 -> count_o=0, full_o=0, y_o=0 next cycle.
REQ-037 The bench SHALL assert reset for 1 cycle after a window of 1,1,1 -> all outputs 0; x_i=1,0 afterward gives y_o=0,0.
